bcp_clause_fetch: RTL
=====================

Name: bcp_clause_fetch

Overview:
- Upstream feeder of sub_clause_evaluator in the BCP path.
- Takes one assigned variable (decided or popped from the imply stack) and walks that variable's occurrence list in memory.
- For each clause on the list: fetches the clause, looks up its literals in the assignment table, and presents one evaluation vector with a single-cycle enable.
- Raises busy for the controller; aborts cleanly when the conflict detector flags a conflict.

Parameters:
- MAX_VARS_BITS, 6, variable index width (2^MAX_VARS_BITS variables).
- VAR_PER_CLAUSE, 3, literal slots per clause.
- CLAUSE_BITS, 8, clause id width (clause memory address).
- OCC_ADDR_BITS, 10, occurrence-list memory address width.
- OCC_CNT_BITS, 8, occurrence count width.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, launch a walk for var_idx_in; accepted only in IDLE.
- var_idx_in, in, MAX_VARS_BITS, variable whose clauses are walked.
- abort, in, 1, conflict seen; terminate the walk.
- assign_valid, in, 2^MAX_VARS_BITS, 1 = variable assigned.
- assign_val, in, 2^MAX_VARS_BITS, assigned value per variable.
- hdr_rd_en, out, 1, occurrence header read strobe.
- hdr_addr, out, MAX_VARS_BITS, header address (= variable).
- hdr_rdata, in, OCC_ADDR_BITS+OCC_CNT_BITS, {base, count}; valid the cycle after hdr_rd_en.
- list_rd_en, out, 1, occurrence list read strobe.
- list_addr, out, OCC_ADDR_BITS, list address.
- list_rdata, in, CLAUSE_BITS, clause id; valid the cycle after list_rd_en.
- cl_rd_en, out, 1, clause memory read strobe.
- cl_addr, out, CLAUSE_BITS, clause id.
- cl_rdata, in, VAR_PER_CLAUSE*(MAX_VARS_BITS+2), literal j at slice j = {mask, pole, var}; valid the cycle after cl_rd_en.
- en, out, 1, evaluator enable (one cycle per clause).
- unassign, out, VAR_PER_CLAUSE, per-literal unassigned flag.
- clause_mask, out, VAR_PER_CLAUSE, literal slot used.
- clause_pole, out, VAR_PER_CLAUSE, literal polarity.
- val, out, VAR_PER_CLAUSE, per-literal current value.
- variable, out, VAR_PER_CLAUSE x MAX_VARS_BITS, literal variable ids.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle pulse when a walk completes without abort.

Behaviour:
- Reset: state IDLE, all counters and registers cleared; every output 0.
- States and transitions:
  - IDLE: on start, capture var_idx_in and go to HDR.
  - HDR: hdr_rd_en=1, hdr_addr=captured var; go to HDR_WAIT.
  - HDR_WAIT: capture base and count, clear index i; count==0 -> DONE, else LIST.
  - LIST: list_rd_en=1, list_addr=base+i, modulo 2^OCC_ADDR_BITS (wrap allowed); go to LIST_WAIT.
  - LIST_WAIT: capture clause id; go to CLAUSE.
  - CLAUSE: cl_rd_en=1, cl_addr=captured clause id; go to CLAUSE_WAIT.
  - CLAUSE_WAIT: capture the clause word; go to EVAL.
  - EVAL: en=1 for exactly one cycle; go to SETTLE.
  - SETTLE: one cycle for the implied assignment to land in assign_*; i++; i==count -> DONE, else LIST.
  - DONE: done=1 for one cycle; go to IDLE.
- EVAL output rules:
  - clause_mask, clause_pole and variable come from the captured clause word.
  - For each masked-in literal j: unassign[j] = ~assign_valid[var_j]; val[j] = assign_val[var_j] & assign_valid[var_j].
  - For masked-out slots: unassign, val and pole are 0.
  - assign_* is sampled combinationally during EVAL.
- en, unassign, clause_mask, clause_pole, val and variable are 0 in every state except EVAL.
- Timing:
  - start is accepted at cycle 0.
  - The EVAL for clause k (0-based) is at cycle 7+6k.
  - done is at cycle 3+6N; for count==0, done is at cycle 3.
- Abort: abort high in any non-IDLE state forces IDLE on the next edge; no done pulse, no further en, busy falls on that edge.
- Abort during EVAL: the en in that cycle is still driven.
- start while busy is ignored.
- start and abort together in IDLE: abort wins, start is ignored.
- count saturates at 2^OCC_CNT_BITS-1 entries; no overflow path exists because i is OCC_CNT_BITS wide and compared for equality.
- reset mid-walk returns to IDLE on the same edge with all outputs 0.

Test Plan:
- Reset for 2 cycles, then idle -> busy=0, done=0, en=0, all strobes 0.
- var 5 with header {base=0x3FE, count=3}, list {3FE:7, 3FF:9, 000:2} -> list_addr sequence 0x3FE, 0x3FF, 0x000 (wrap); en at cycles 7, 13, 19 with cl_addr 7, 9, 2; done at cycle 21.
- Clause {(m1,p0,v4),(m1,p1,v5),(m0)}, assign_valid[4]=0, assign_valid[5]=1, assign_val[5]=0 -> at EVAL: unassign=3'b001, val=3'b000, clause_mask=3'b011, clause_pole=3'b010.
- Header count=0 -> no list/clause reads, done at cycle 3, en never asserted.
- count=4, abort asserted at the second EVAL -> that en still fires; busy=0 next cycle; no done pulse; no third list read.
- start pulses at cycles 2 and 5 during a walk, and start with abort in IDLE -> all ignored; the walk completes unchanged with exactly one done.

Source files
------------

// File: rtl/bcp_clause_fetch_if.sv
// ---------------------------------------------------------------------------
// bcp_clause_fetch_if
//
// Purpose: bundles every non-clock signal of bcp_clause_fetch: the command
// side (start/abort/variable), the assignment-table view, the three memory
// read ports (occurrence header, occurrence list, clause memory) and the
// evaluation vector handed to the sub-clause evaluator.
//
// Modports:
//   slave  - the clause fetch unit (takes commands, drives read strobes and
//            the evaluation vector)
//   master - the surrounding controller / memories (drives commands, read
//            data and the assignment table)
// ---------------------------------------------------------------------------
interface bcp_clause_fetch_if #(
    parameter int MAX_VARS_BITS  = 6,
    parameter int VAR_PER_CLAUSE = 3,
    parameter int CLAUSE_BITS    = 8,
    parameter int OCC_ADDR_BITS  = 10,
    parameter int OCC_CNT_BITS   = 8
);
    localparam int NUM_VARS = 1 << MAX_VARS_BITS;
    localparam int LIT_BITS = MAX_VARS_BITS + 2;

    logic                                      start;
    logic [MAX_VARS_BITS-1:0]                  var_idx_in;
    logic                                      abort;
    logic [NUM_VARS-1:0]                       assign_valid;
    logic [NUM_VARS-1:0]                       assign_val;

    logic                                      hdr_rd_en;
    logic [MAX_VARS_BITS-1:0]                  hdr_addr;
    logic [OCC_ADDR_BITS+OCC_CNT_BITS-1:0]     hdr_rdata;

    logic                                      list_rd_en;
    logic [OCC_ADDR_BITS-1:0]                  list_addr;
    logic [CLAUSE_BITS-1:0]                    list_rdata;

    logic                                      cl_rd_en;
    logic [CLAUSE_BITS-1:0]                    cl_addr;
    logic [VAR_PER_CLAUSE*LIT_BITS-1:0]        cl_rdata;

    logic                                      en;
    logic [VAR_PER_CLAUSE-1:0]                 unassign;
    logic [VAR_PER_CLAUSE-1:0]                 clause_mask;
    logic [VAR_PER_CLAUSE-1:0]                 clause_pole;
    logic [VAR_PER_CLAUSE-1:0]                 val;
    logic [VAR_PER_CLAUSE*MAX_VARS_BITS-1:0]   variable;
    logic                                      busy;
    logic                                      done;

    modport slave (
        input  start, var_idx_in, abort, assign_valid, assign_val,
        input  hdr_rdata, list_rdata, cl_rdata,
        output hdr_rd_en, hdr_addr, list_rd_en, list_addr, cl_rd_en, cl_addr,
        output en, unassign, clause_mask, clause_pole, val, variable, busy, done
    );

    modport master (
        output start, var_idx_in, abort, assign_valid, assign_val,
        output hdr_rdata, list_rdata, cl_rdata,
        input  hdr_rd_en, hdr_addr, list_rd_en, list_addr, cl_rd_en, cl_addr,
        input  en, unassign, clause_mask, clause_pole, val, variable, busy, done
    );
endinterface

// File: rtl/bcp_clause_fetch.sv
// ---------------------------------------------------------------------------
// bcp_clause_fetch
//
// Purpose: upstream feeder of the sub-clause evaluator in the BCP path. For
// one assigned variable it reads the occurrence header {base, count}, then
// for every list entry fetches the clause id, fetches the clause word and
// presents one evaluation vector (literal fields plus their current
// assignment state) with a single-cycle enable. An abort from the conflict
// detector drops the walk back to IDLE on the next edge.
//
// Ports:
//   clock - system clock
//   reset - synchronous active-high reset
//   bus   - bcp_clause_fetch_if.slave: command, assignment table, memory
//           read ports, evaluation vector, busy/done
// ---------------------------------------------------------------------------
module bcp_clause_fetch #(
    parameter int MAX_VARS_BITS  = 6,
    parameter int VAR_PER_CLAUSE = 3,
    parameter int CLAUSE_BITS    = 8,
    parameter int OCC_ADDR_BITS  = 10,
    parameter int OCC_CNT_BITS   = 8
) (
    input logic               clock,
    input logic               reset,
    bcp_clause_fetch_if.slave bus
);
    localparam int LIT_BITS  = MAX_VARS_BITS + 2;
    localparam int WORD_BITS = VAR_PER_CLAUSE * LIT_BITS;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        HDR_WAIT,
        LIST,
        LIST_WAIT,
        CLAUSE,
        CLAUSE_WAIT,
        EVAL,
        SETTLE,
        DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [MAX_VARS_BITS-1:0] varIdx_q, varIdx_d;
    logic [OCC_ADDR_BITS-1:0] base_q, base_d;
    logic [OCC_CNT_BITS-1:0]  count_q, count_d;
    logic [OCC_CNT_BITS-1:0]  idx_q, idx_d;
    logic [CLAUSE_BITS-1:0]   clauseId_q, clauseId_d;
    logic [WORD_BITS-1:0]     clauseWord_q, clauseWord_d;

    // State and walk registers; reset clears everything so all outputs,
    // which decode from these, come out 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            varIdx_q     <= '0;
            base_q       <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            clauseId_q   <= '0;
            clauseWord_q <= '0;
        end else begin
            state_q      <= state_d;
            varIdx_q     <= varIdx_d;
            base_q       <= base_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            clauseId_q   <= clauseId_d;
            clauseWord_q <= clauseWord_d;
        end
    end

    // Next-state and output decode. Each memory access is a strobe state
    // followed by a wait state that captures the read data, since all three
    // memories return data the cycle after the strobe.
    always_comb begin
        state_d      = state_q;
        varIdx_d     = varIdx_q;
        base_d       = base_q;
        count_d      = count_q;
        idx_d        = idx_q;
        clauseId_d   = clauseId_q;
        clauseWord_d = clauseWord_q;

        bus.hdr_rd_en   = 1'b0;
        bus.hdr_addr    = '0;
        bus.list_rd_en  = 1'b0;
        bus.list_addr   = '0;
        bus.cl_rd_en    = 1'b0;
        bus.cl_addr     = '0;
        bus.en          = 1'b0;
        bus.unassign    = '0;
        bus.clause_mask = '0;
        bus.clause_pole = '0;
        bus.val         = '0;
        bus.variable    = '0;
        bus.done        = 1'b0;
        bus.busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    varIdx_d = bus.var_idx_in;
                    state_d  = HDR;
                end
            end
            HDR: begin
                bus.hdr_rd_en = 1'b1;
                bus.hdr_addr  = varIdx_q;
                state_d       = HDR_WAIT;
            end
            HDR_WAIT: begin
                base_d  = bus.hdr_rdata[OCC_ADDR_BITS+OCC_CNT_BITS-1 -: OCC_ADDR_BITS];
                count_d = bus.hdr_rdata[OCC_CNT_BITS-1:0];
                idx_d   = '0;
                state_d = (bus.hdr_rdata[OCC_CNT_BITS-1:0] == '0) ? DONE : LIST;
            end
            LIST: begin
                // The list may straddle the top of the occurrence memory;
                // the adder simply wraps.
                bus.list_rd_en = 1'b1;
                bus.list_addr  = base_q + OCC_ADDR_BITS'(idx_q);
                state_d        = LIST_WAIT;
            end
            LIST_WAIT: begin
                clauseId_d = bus.list_rdata;
                state_d    = CLAUSE;
            end
            CLAUSE: begin
                bus.cl_rd_en = 1'b1;
                bus.cl_addr  = clauseId_q;
                state_d      = CLAUSE_WAIT;
            end
            CLAUSE_WAIT: begin
                clauseWord_d = bus.cl_rdata;
                state_d      = EVAL;
            end
            EVAL: begin
                // Assignment state is looked up live so that an implication
                // landed during the previous SETTLE is already visible.
                // Masked-out slots keep pole/unassign/val at 0.
                bus.en = 1'b1;
                for (int j = 0; j < VAR_PER_CLAUSE; j++) begin
                    bus.variable[j*MAX_VARS_BITS +: MAX_VARS_BITS] =
                        clauseWord_q[j*LIT_BITS +: MAX_VARS_BITS];
                    if (clauseWord_q[j*LIT_BITS + MAX_VARS_BITS + 1]) begin
                        bus.clause_mask[j] = 1'b1;
                        bus.clause_pole[j] = clauseWord_q[j*LIT_BITS + MAX_VARS_BITS];
                        bus.unassign[j] =
                            ~bus.assign_valid[clauseWord_q[j*LIT_BITS +: MAX_VARS_BITS]];
                        bus.val[j] =
                            bus.assign_val[clauseWord_q[j*LIT_BITS +: MAX_VARS_BITS]] &
                            bus.assign_valid[clauseWord_q[j*LIT_BITS +: MAX_VARS_BITS]];
                    end
                end
                state_d = SETTLE;
            end
            SETTLE: begin
                // Equality compare on an index as wide as the count means a
                // full 255-entry list terminates without any overflow case.
                idx_d   = idx_q + 1'b1;
                state_d = (idx_d == count_q) ? DONE : LIST;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A conflict ends the walk from any active state; outputs of the
        // current cycle (including an EVAL enable) are left untouched.
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
        end
    end
endmodule
